// File: rtl/lenet_pkg.sv
// Shared LeNet-5 constants: layer indices, sequencer state encoding and
// ping-pong buffer sizes (words) for each layer's output feature map.
package lenet_pkg;

    localparam int unsigned NUM_LAYERS = 7;

    localparam int unsigned L_CONV1 = 0;
    localparam int unsigned L_POOL1 = 1;
    localparam int unsigned L_CONV2 = 2;
    localparam int unsigned L_POOL2 = 3;
    localparam int unsigned L_FC1   = 4;
    localparam int unsigned L_FC2   = 5;
    localparam int unsigned L_FC3   = 6;

    localparam int unsigned BUF_CONV1_OUT = 4704;  // 6x28x28
    localparam int unsigned BUF_POOL1_OUT = 1176;  // 6x14x14
    localparam int unsigned BUF_CONV2_OUT = 1600;  // 16x10x10
    localparam int unsigned BUF_POOL2_OUT = 400;   // 16x5x5
    localparam int unsigned BUF_FC1_OUT   = 120;
    localparam int unsigned BUF_FC2_OUT   = 84;
    localparam int unsigned BUF_FC3_OUT   = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StNext,
        StFinish,
        StFault
    } seq_state_t;

endpackage

// File: rtl/lenet_watchdog.sv
// Per-layer watchdog: counter cleared by load, advanced by en, with a flag
// raised when the count reaches TIMEOUT_CYC-1.
module lenet_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned CYC_W       = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CYC_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CYC_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Top-level LeNet-5 scheduler: launches each layer engine in turn, swaps the
// ping-pong buffer roles between layers and faults a layer that stalls.
module lenet_layer_sequencer #(
    parameter int unsigned NUM_LAYERS  = lenet_pkg::NUM_LAYERS,
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned CYC_W       = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic                  src_sel,
    output logic [2:0]            cur_layer,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            err_layer,
    output logic [CYC_W-1:0]      total_cycles
);
    import lenet_pkg::*;

    seq_state_t       state_q, state_d;
    logic [CYC_W-1:0] run_cnt_q, run_cnt_inc;
    logic             wd_tc;
    logic             last_layer;
    logic             cur_done;

    assign last_layer  = (cur_layer == 3'(NUM_LAYERS - 1));
    assign cur_done    = layer_done[cur_layer];
    assign run_cnt_inc = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 1'b1;

    lenet_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CYC_W      (CYC_W)
    ) u_watchdog (
        .clk (clk),
        .rst (rst),
        .load(state_q == StLaunch),
        .en  (state_q == StWait),
        .tc  (wd_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StLaunch;
            StLaunch: state_d = StWait;
            StWait: begin
                // A completing layer beats a simultaneous watchdog expiry.
                if (cur_done)   state_d = StNext;
                else if (wd_tc) state_d = StFault;
            end
            StNext:   state_d = last_layer ? StFinish : StLaunch;
            StFinish: state_d = StIdle;
            StFault:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            run_cnt_q    <= '0;
            layer_start  <= '0;
            src_sel      <= 1'b0;
            cur_layer    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_layer    <= '0;
            total_cycles <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= (state_d != StIdle);
            layer_start <= '0;
            done        <= 1'b0;
            if (state_q != StIdle) run_cnt_q <= run_cnt_inc;
            if (!abort) begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            cur_layer <= '0;
                            src_sel   <= 1'b0;
                            error     <= 1'b0;
                            run_cnt_q <= '0;
                        end
                    end
                    StLaunch: layer_start <= NUM_LAYERS'(1) << cur_layer;
                    StNext: begin
                        src_sel <= ~src_sel;
                        if (!last_layer) cur_layer <= cur_layer + 3'd1;
                    end
                    StFinish: begin
                        done         <= 1'b1;
                        total_cycles <= run_cnt_inc;
                    end
                    StFault: begin
                        error     <= 1'b1;
                        err_layer <= cur_layer;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Scoreboard bench for lenet_layer_sequencer: a per-run reference model queues
// the expected launches and outcome; a negedge monitor pops and compares them.
module tb_lenet_layer_sequencer;

    localparam int NL = 7;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NL-1:0] layer_done;
    logic [NL-1:0] layer_start;
    logic          src_sel;
    logic [2:0]    cur_layer;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    err_layer;
    logic [23:0]   total_cycles;

    lenet_layer_sequencer #(
        .NUM_LAYERS (NL),
        .TIMEOUT_CYC(TO),
        .CYC_W      (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .layer_done  (layer_done),
        .layer_start (layer_start),
        .src_sel     (src_sel),
        .cur_layer   (cur_layer),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_layer   (err_layer),
        .total_cycles(total_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit fault;
        int val;
    } res_t;

    int   exp_launch[$];
    res_t exp_res[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   exp_total = 0;
    int   dly[NL];

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: layer k launches with src_sel = k mod 2; a layer that
    // answers d cycles after its launch costs d+2 cycles, plus one to start.
    // A layer that never answers faults; abort/reset end the run silently.
    function automatic void model_run(input int abort_layer, input int rst_layer);
        int total = 1;
        for (int k = 0; k < NL; k++) begin
            exp_launch.push_back(k);
            if (k == abort_layer || k == rst_layer) return;
            if (dly[k] == 0) begin
                exp_res.push_back('{fault: 1'b1, val: k});
                return;
            end
            total += dly[k] + 2;
        end
        exp_res.push_back('{fault: 1'b0, val: total});
        exp_total = total;
    endfunction

    // Monitor
    int   mon_launch_cyc = 0;
    int   mon_e;
    res_t mon_r;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (layer_start != '0) begin
                mon_launch_cyc = cyc;
                if (exp_launch.size() == 0) begin
                    chk("launch_unexpected", layer_start, 0);
                end else begin
                    mon_e = exp_launch.pop_front();
                    chk("launch_onehot", layer_start, 1 << mon_e);
                    chk("launch_src_sel", src_sel, mon_e % 2);
                    chk("launch_cur_layer", cur_layer, mon_e);
                end
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    mon_r = exp_res.pop_front();
                    chk("done_kind", done, mon_r.fault ? 0 : 1);
                    if (!mon_r.fault) begin
                        chk("total_cycles", total_cycles, mon_r.val);
                        chk("done_error", error, 0);
                    end
                end
            end
            if (error && !err_prev) begin
                if (exp_res.size() == 0) begin
                    chk("fault_unexpected", error, 0);
                end else begin
                    mon_r = exp_res.pop_front();
                    chk("fault_kind", error, mon_r.fault ? 1 : 0);
                    chk("err_layer", err_layer, mon_r.val);
                    chk("fault_busy", busy, 0);
                    chk("fault_latency", cyc - mon_launch_cyc, TO + 1);
                end
            end
        end
        err_prev = error;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_layer_start"}, layer_start, 0);
        chk({tag, "_src_sel"}, src_sel, 0);
        chk({tag, "_cur_layer"}, cur_layer, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_err_layer"}, err_layer, 0);
        chk({tag, "_total_cycles"}, total_cycles, 0);
    endtask

    // Runs one inference; the responder answers layer k dly[k] cycles after
    // its launch (0 = never). abort/rst fire 3 cycles into the named layer.
    task automatic do_run(input int abort_layer, input bit spur, input int rst_layer);
        int k = -1;
        int pend_k = 0;
        int pend_at = 0;
        int launch_at = 0;
        int act_at = -1;
        bit pend = 1'b0;
        bit ended = 1'b0;
        model_run(abort_layer, rst_layer);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_clears_error", error, 0);
        for (int budget = 0; budget < 2000 && !ended; budget++) begin
            layer_done = '0;
            start      = 1'b0;
            if (layer_start != '0) begin
                for (int i = 0; i < NL; i++) if (layer_start[i]) k = i;
                launch_at = cyc;
                if (k == abort_layer || k == rst_layer) begin
                    act_at = cyc + 3;
                end else if (dly[k] != 0) begin
                    pend    = 1'b1;
                    pend_k  = k;
                    pend_at = cyc + dly[k] - 1;
                end
            end
            if (pend && cyc == pend_at) begin
                layer_done[pend_k] = 1'b1;
                pend = 1'b0;
            end
            if (spur && k == 0 && cyc == launch_at + 3) begin
                layer_done[3] = 1'b1;
                start         = 1'b1;
            end
            if (act_at >= 0 && cyc == act_at) begin
                if (abort_layer >= 0) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_busy", busy, 0);
                    chk("abort_layer_start", layer_start, 0);
                    chk("abort_error", error, 0);
                    chk("abort_total_kept", total_cycles, exp_total);
                end else begin
                    #2 rst = 1'b1;
                    #1 chk_reset_outputs("async_rst");
                    exp_total = 0;
                    @(negedge clk);
                    rst = 1'b0;
                end
                ended = 1'b1;
            end else begin
                @(negedge clk);
                layer_done = '0;
                start      = 1'b0;
                if (!busy) ended = 1'b1;
            end
        end
        if (!ended) chk("run_budget", busy, 0);
        @(negedge clk);
        @(negedge clk);
        chk("launch_queue_drained", exp_launch.size(), 0);
        chk("result_queue_drained", exp_res.size(), 0);
        exp_launch.delete();
        exp_res.delete();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        layer_done = '0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Normal run with fixed 10-cycle layers
        foreach (dly[i]) dly[i] = 10;
        do_run(-1, 1'b0, -1);
        chk("normal_total_85", total_cycles, 85);
        chk("normal_error", error, 0);

        // pool1 never finishes
        dly[1] = 0;
        do_run(-1, 1'b0, -1);
        chk("timeout_error", error, 1);
        chk("timeout_err_layer", err_layer, 1);

        // Abort during fc1
        foreach (dly[i]) dly[i] = 10;
        dly[4] = 20;
        do_run(4, 1'b0, -1);

        // Stray layer_done[3] and start during layer 0
        foreach (dly[i]) dly[i] = 10;
        do_run(-1, 1'b1, -1);

        // Done on the watchdog's final cycle
        dly[0] = TO;
        dly[3] = TO;
        do_run(-1, 1'b0, -1);
        chk("race_error", error, 0);

        // Async reset while waiting on conv2, then a clean run
        foreach (dly[i]) dly[i] = 10;
        do_run(-1, 1'b0, 2);
        do_run(-1, 1'b0, -1);

        for (int r = 0; r < 14; r++) begin
            foreach (dly[i]) begin
                dly[i] = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, TO));
            end
            do_run(-1, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
